bp_fb_sched: RTL and testbench

Feedback scheduler for the branch predictor's BHT update port. Accepts resolved-branch outcomes from two requesters (req0 = branch unit, req1 = commit stage) under round-robin arbitration. Buffers them in a small FIFO and drives the predictor's single-entry-per-cycle feedback port (fb_ena/fb_tk/fb_pc). Updates are deferred while the fetch-side lookup (pd_pc) hits the same BHT index; a bounded hold counter prevents starvation.

---
 rtl/bp_fb_sched_pkg.sv | 24 ++
 rtl/bp_fb_sched_fifo.sv | 68 ++++++
 rtl/bp_fb_sched.sv | 114 +++++++++++
 tb/tb_bp_fb_sched.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_fb_sched_pkg.sv
// Shared definitions for the BHT feedback scheduler and the predictor.
// Holds the address type and index hash macros plus the queued entry layout.
// No logic: types and constants only.
`ifndef BP_UTILS_DEFS
`define BP_UTILS_DEFS
`define ADDR_TP   31:0
`define ADDR_HASH 9:2
`define TRUE      1'b1
`define FALSE     1'b0
`endif

package bp_fb_sched_pkg;

    localparam int ADDR_W = 32;

    // One resolved-branch outcome as stored in the feedback queue.
    typedef struct packed {
        logic              tk;
        logic [`ADDR_TP]   pc;
    } fb_entry_t;

    localparam int ENTRY_W = $bits(fb_entry_t);

endpackage

// File: rtl/bp_fb_sched_fifo.sv
// Generic synchronous FIFO used as the feedback queue (module fb_fifo).
// Latency: a pushed word is visible at head the cycle after the push edge.
// Backpressure: caller must not push when full or pop when empty; clr empties it.
module fb_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic [W-1:0]     head_dat,
    output logic [PTR_W:0]   count
);

    logic [W-1:0]   mem_q [DEPTH];
    logic [W-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    // Next-state: pointers wrap naturally at DEPTH, occupancy tracked separately.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the consumer masks head while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/bp_fb_sched.sv
// Feedback scheduler: round-robin two requesters into a queue feeding the BHT update port.
// Latency: accepted at edge E, fb_ena may assert in cycle E+1 (no bypass).
// Backpressure: reqN_rdy is a same-cycle grant; low when full, flushing, in reset or rdy low.
module bp_fb_sched
    import bp_fb_sched_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PTR_W    = 2,
    parameter int HOLD_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              req0_vld,
    input  logic              req0_tk,
    input  logic [`ADDR_TP]   req0_pc,
    output logic              req0_rdy,
    input  logic              req1_vld,
    input  logic              req1_tk,
    input  logic [`ADDR_TP]   req1_pc,
    output logic              req1_rdy,
    input  logic [`ADDR_TP]   pd_pc,
    output logic              fb_ena,
    output logic              fb_tk,
    output logic [`ADDR_TP]   fb_pc,
    output logic [PTR_W:0]    q_cnt
);

    localparam int HOLD_W = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(DEPTH);

    logic              last_grant_q, last_grant_d;   // 1: req1 won the last push
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic      can_push, grant0, grant1, push, pop, empty, collide;
    fb_entry_t push_ent, head_ent;

    // Only the hashed index bits of the lookup PC take part in the compare.
    logic      unused_pd_bits;
    assign unused_pd_bits = ^{pd_pc[31:10], pd_pc[1:0]};

    assign empty    = (q_cnt == '0);
    assign can_push = rdy & ~rst & ~clr & (q_cnt != FULL_CNT);

    // Tie goes to whoever did not win the last accepted push.
    assign grant0   = req0_vld & (~req1_vld | last_grant_q);
    assign grant1   = req1_vld & (~req0_vld | ~last_grant_q);
    assign req0_rdy = can_push & grant0;
    assign req1_rdy = can_push & grant1;
    assign push     = req0_rdy | req1_rdy;

    always_comb begin
        push_ent = '0;
        if (grant0) begin
            push_ent.tk = req0_tk;
            push_ent.pc = req0_pc;
        end else begin
            push_ent.tk = req1_tk;
            push_ent.pc = req1_pc;
        end
    end

    fb_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr & rdy),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .head_dat (head_ent),
        .count    (q_cnt)
    );

    // Defer while fetch is looking up the same BHT row, unless held too long.
    assign collide = ~empty & (head_ent.pc[`ADDR_HASH] == pd_pc[`ADDR_HASH]);
    assign fb_ena  = rdy & ~rst & ~clr & ~empty & (~collide | (hold_cnt_q == HOLD_LIM));
    assign pop     = fb_ena;
    assign fb_tk   = empty ? 1'b0 : head_ent.tk;
    assign fb_pc   = empty ? '0   : head_ent.pc;

    // Arbiter memory and starvation counter; everything frozen while rdy is low.
    always_comb begin
        last_grant_d = last_grant_q;
        hold_cnt_d   = hold_cnt_q;
        if (rdy) begin
            if (push) begin
                last_grant_d = req1_rdy;
            end
            if (clr || pop) begin
                hold_cnt_d = '0;
            end else if (collide && (hold_cnt_q < HOLD_LIM)) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end
    end

    // Reset makes req0 the winner of the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            hold_cnt_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

endmodule

// File: tb/tb_bp_fb_sched.sv
module tb_bp_fb_sched;

    logic        clk = 1'b0;
    logic        rst, rdy, clr;
    logic        req0_vld, req0_tk, req1_vld, req1_tk;
    logic [31:0] req0_pc, req1_pc, pd_pc;
    logic        req0_rdy, req1_rdy, fb_ena, fb_tk;
    logic [31:0] fb_pc;
    logic [2:0]  q_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bp_fb_sched #(.DEPTH(4), .PTR_W(2), .HOLD_MAX(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .clr      (clr),
        .req0_vld (req0_vld),
        .req0_tk  (req0_tk),
        .req0_pc  (req0_pc),
        .req0_rdy (req0_rdy),
        .req1_vld (req1_vld),
        .req1_tk  (req1_tk),
        .req1_pc  (req1_pc),
        .req1_rdy (req1_rdy),
        .pd_pc    (pd_pc),
        .fb_ena   (fb_ena),
        .fb_tk    (fb_tk),
        .fb_pc    (fb_pc),
        .q_cnt    (q_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then let inputs/outputs settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; clr = 1'b0;
        req0_vld = 1'b0; req0_tk = 1'b0; req0_pc = '0;
        req1_vld = 1'b0; req1_tk = 1'b0; req1_pc = '0;
        pd_pc = '0;
        tick();
        // Request during reset must not be granted.
        req0_vld = 1'b1; req0_pc = 32'h900;
        #1;
        chk("rst_req0_rdy", {31'd0, req0_rdy}, 32'd0);
        tick();
        rst = 1'b0; req0_vld = 1'b0;
        #1;
        chk("rst_qcnt", {29'd0, q_cnt}, 32'd0);
        chk("rst_fb_ena", {31'd0, fb_ena}, 32'd0);
        chk("rst_fb_pc", fb_pc, 32'd0);
        chk("rst_fb_tk", {31'd0, fb_tk}, 32'd0);

        // Single push and drain.
        req0_vld = 1'b1; req0_pc = 32'h100; req0_tk = 1'b1;
        #1;
        chk("push0_rdy", {31'd0, req0_rdy}, 32'd1);
        tick();
        req0_vld = 1'b0;
        #1;
        chk("push0_ena", {31'd0, fb_ena}, 32'd1);
        chk("push0_pc", fb_pc, 32'h100);
        chk("push0_tk", {31'd0, fb_tk}, 32'd1);
        chk("push0_cnt", {29'd0, q_cnt}, 32'd1);
        tick();
        chk("drain0_cnt", {29'd0, q_cnt}, 32'd0);
        chk("drain0_ena", {31'd0, fb_ena}, 32'd0);

        // Lone req1 push; afterwards req1 is last winner so req0 takes the next tie.
        req1_vld = 1'b1; req1_pc = 32'h200; req1_tk = 1'b0;
        #1;
        chk("push1_rdy", {31'd0, req1_rdy}, 32'd1);
        tick();
        req1_vld = 1'b0;
        #1;
        chk("push1_pc", fb_pc, 32'h200);
        tick();

        // Both requesting: grants alternate, outputs stream one per cycle.
        req0_vld = 1'b1; req0_pc = 32'h10; req0_tk = 1'b1;
        req1_vld = 1'b1; req1_pc = 32'h20; req1_tk = 1'b0;
        #1;
        chk("rr_a_r0", {31'd0, req0_rdy}, 32'd1);
        chk("rr_a_r1", {31'd0, req1_rdy}, 32'd0);
        tick();
        req0_pc = 32'h30;
        #1;
        chk("rr_b_r1", {31'd0, req1_rdy}, 32'd1);
        chk("rr_b_r0", {31'd0, req0_rdy}, 32'd0);
        chk("rr_b_pc", fb_pc, 32'h10);
        chk("rr_b_tk", {31'd0, fb_tk}, 32'd1);
        tick();
        req1_pc = 32'h40;
        #1;
        chk("rr_c_r0", {31'd0, req0_rdy}, 32'd1);
        chk("rr_c_pc", fb_pc, 32'h20);
        chk("rr_c_tk", {31'd0, fb_tk}, 32'd0);
        tick();
        req0_pc = 32'h50;
        #1;
        chk("rr_d_r1", {31'd0, req1_rdy}, 32'd1);
        chk("rr_d_pc", fb_pc, 32'h30);
        chk("rr_d_cnt", {29'd0, q_cnt}, 32'd1);
        tick();
        req0_vld = 1'b0; req1_vld = 1'b0;
        #1;
        chk("rr_e_pc", fb_pc, 32'h40);
        chk("rr_e_ena", {31'd0, fb_ena}, 32'd1);
        tick();
        chk("rr_f_cnt", {29'd0, q_cnt}, 32'd0);

        // Collision: same index [9:2], forced issue on the 4th cycle at head.
        pd_pc = 32'h504;
        req0_vld = 1'b1; req0_pc = 32'h104; req0_tk = 1'b1;
        tick();
        req0_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("coll_hold%0d", i), {31'd0, fb_ena}, 32'd0);
            tick();
        end
        #1;
        chk("coll_force", {31'd0, fb_ena}, 32'd1);
        chk("coll_pc", fb_pc, 32'h104);
        tick();
        chk("coll_empty", {29'd0, q_cnt}, 32'd0);

        // Full: four colliding pushes accepted, fifth refused while head is forced out.
        req0_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_pc = 32'h104 + 32'h400 * i;
            #1;
            chk($sformatf("full_push%0d", i), {31'd0, req0_rdy}, 32'd1);
            tick();
        end
        req0_pc = 32'h1104;
        #1;
        chk("full_refuse", {31'd0, req0_rdy}, 32'd0);
        chk("full_cnt", {29'd0, q_cnt}, 32'd4);
        chk("full_force", {31'd0, fb_ena}, 32'd1);
        tick();
        req0_vld = 1'b0;
        #1;
        chk("full_after_cnt", {29'd0, q_cnt}, 32'd3);
        chk("full_after_ena", {31'd0, fb_ena}, 32'd0);
        chk("full_after_pc", fb_pc, 32'h504);

        // Flush with three queued.
        clr = 1'b1;
        #1;
        chk("clr_ena", {31'd0, fb_ena}, 32'd0);
        tick();
        clr = 1'b0;
        #1;
        chk("clr_cnt", {29'd0, q_cnt}, 32'd0);
        chk("clr_fb_ena", {31'd0, fb_ena}, 32'd0);
        chk("clr_fb_pc", fb_pc, 32'd0);

        // Freeze: two entries queued behind a colliding head, then rdy low.
        req0_vld = 1'b1; req0_pc = 32'h104;
        tick();
        req0_pc = 32'h204;
        tick();
        rdy = 1'b0; req0_pc = 32'h304;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("frz_cnt%0d", i), {29'd0, q_cnt}, 32'd2);
            chk($sformatf("frz_ena%0d", i), {31'd0, fb_ena}, 32'd0);
            chk($sformatf("frz_rdy%0d", i), {31'd0, req0_rdy}, 32'd0);
            tick();
        end
        rdy = 1'b1; req0_vld = 1'b0; pd_pc = 32'd0;
        #1;
        chk("thaw_ena", {31'd0, fb_ena}, 32'd1);
        chk("thaw_pc", fb_pc, 32'h104);
        chk("thaw_cnt", {29'd0, q_cnt}, 32'd2);
        tick();
        chk("thaw2_pc", fb_pc, 32'h204);
        tick();
        chk("thaw_empty", {29'd0, q_cnt}, 32'd0);

        // Reset mid-operation discards the queued entry.
        req0_vld = 1'b1; req0_pc = 32'h700; req0_tk = 1'b1;
        tick();
        req0_vld = 1'b0; rst = 1'b1;
        #1;
        chk("mrst_ena", {31'd0, fb_ena}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_cnt", {29'd0, q_cnt}, 32'd0);
        chk("mrst_pc", fb_pc, 32'd0);
        chk("mrst_tk", {31'd0, fb_tk}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
